fetch_unit: RTL and testbench

Instruction fetch stage for the RV32I core. Owns the program counter and drives the instruction memory's word address. Captures the combinationally returned instruction word, together with its PC, into a 2-entry fetch buffer, and presents it to decode over a valid/ready handshake. Also handles branch/jump redirects and a fetch-address security check: a misaligned or out-of-range PC produces a fault entry and halts fetch until the next redirect.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_buffer.sv | 68 ++++++
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  // A fetch address is illegal when misaligned or beyond the instruction memory.
  function automatic logic pcIsIllegal(input logic [31:0] pc, input int unsigned words);
    logic [32:0] limit;
    limit = {1'b0, words} << 2;
    return (pc[1:0] != 2'b00) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        fetch_halted;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_fault, fetch_halted,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_fault, fetch_halted,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries; flush beats push and pop in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_entry,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output fetch_entry_t     o_head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_entry;
        r_wrPtr        <= ptrNext(r_wrPtr);
      end
      if (w_doPop) begin
        r_rdPtr <= ptrNext(r_rdPtr);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, fetch-address check
// and RUN/HALT control feeding a small buffer towards decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master io_fetch
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_stateNext;
  logic [31:0]      r_pc;
  logic [31:0]      w_pcNext;
  logic             w_fault;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_entry;
  fetch_entry_t     w_head;

  assign w_fault = pcIsIllegal(r_pc, IMEM_WORDS);
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && io_fetch.id_ready;
  assign w_push  = (r_state == RUN) && (!w_full || w_pop);

  // A faulting PC is recorded as a NOP-carrying fault entry so decode sees it in order.
  always_comb begin
    w_entry.instr = w_fault ? NOP_INSTR : io_fetch.imem_rdata;
    w_entry.pc    = r_pc;
    w_entry.fault = w_fault;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
    end
  end

  // Redirect wins over any fetch progress in the same cycle.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    if (io_fetch.redirect_valid) begin
      w_stateNext = RUN;
      w_pcNext    = io_fetch.redirect_pc;
    end else if (w_push) begin
      if (w_fault) begin
        w_stateNext = HALT;
      end else begin
        w_pcNext = r_pc + 32'd4;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (io_fetch.redirect_valid),
    .i_entry (w_entry),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign io_fetch.imem_addr    = r_pc;
  assign io_fetch.fetch_halted = (r_state == HALT);
  assign io_fetch.id_valid     = w_valid;
  assign io_fetch.id_instr     = w_empty ? NOP_INSTR : w_head.instr;
  assign io_fetch.id_pc        = w_empty ? 32'd0 : w_head.pc;
  assign io_fetch.id_fault     = w_empty ? 1'b0 : w_head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based reference model predicts the
// decode-side entry stream, and a monitor compares it every cycle.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned WORDS  = 1024;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } expEntry_t;

  logic clk = 1'b0;
  logic rst_n;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .IMEM_WORDS (WORDS),
    .BUF_DEPTH  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_fetch (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [WORDS];
  assign bus.imem_rdata = (bus.imem_addr < 32'(4 * WORDS)) ? mem[bus.imem_addr[11:2]] : 32'hDEAD_BEEF;

  expEntry_t   expQ [$];
  logic [31:0] mPc;
  bit          mHalted;
  int          checks   = 0;
  int          failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rdy, input bit redir, input logic [31:0] tgt);
    @(negedge clk);
    bus.id_ready       = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
  endtask

  // Asynchronous reset mid-cycle: outputs must drop to reset values without a clock edge.
  task automatic doReset();
    #3;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    checkOutput("rst_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("rst_id_instr", bus.id_instr, NOP_INSTR);
    checkOutput("rst_id_pc", bus.id_pc, 32'd0);
    checkOutput("rst_id_fault", 32'(bus.id_fault), 32'd0);
    checkOutput("rst_fetch_halted", 32'(bus.fetch_halted), 32'd0);
    checkOutput("rst_imem_addr", bus.imem_addr, RST_PC);
    expQ.delete();
    mPc     = RST_PC;
    mHalted = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: one step per clock edge, following the fetch rules directly.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.redirect_valid) begin
        expQ.delete();
        mPc     = bus.redirect_pc;
        mHalted = 1'b0;
      end else if (!mHalted && expQ.size() < 2) begin
        if ((mPc % 4 != 0) || (mPc >= 4 * WORDS)) begin
          expQ.push_back('{NOP_INSTR, mPc, 1'b1});
          mHalted = 1'b1;
        end else begin
          expQ.push_back('{mem[mPc / 4], mPc, 1'b0});
          mPc = mPc + 32'd4;
        end
      end
    end
  end

  // Monitor: compares the presented head and status against the model each cycle.
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      checkOutput("id_valid", 32'(bus.id_valid), 32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("id_instr", bus.id_instr, expQ[0].instr);
        checkOutput("id_pc", bus.id_pc, expQ[0].pc);
        checkOutput("id_fault", 32'(bus.id_fault), 32'(expQ[0].fault));
        if (bus.id_ready) begin
          void'(expQ.pop_front());
        end
      end else begin
        checkOutput("empty_id_instr", bus.id_instr, NOP_INSTR);
        checkOutput("empty_id_pc", bus.id_pc, 32'd0);
        checkOutput("empty_id_fault", 32'(bus.id_fault), 32'd0);
      end
      checkOutput("imem_addr", bus.imem_addr, mPc);
      checkOutput("fetch_halted", 32'(bus.fetch_halted), 32'(mHalted));
    end
  end

  initial begin
    logic [31:0] tgt;
    int          sel;
    bit          rd;

    for (int i = 0; i < WORDS; i++) begin
      mem[i] = $urandom;
    end
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h0050_0113;

    rst_n              = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    $display("[TB] sequential fetch from reset");
    doReset();
    repeat (12) applyStimulus(1'b1, 1'b0, 32'd0);

    $display("[TB] decode stall then release");
    bus.id_ready = 1'b0;
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b0, 32'd0);
    repeat (6) applyStimulus(1'b1, 1'b0, 32'd0);

    $display("[TB] redirect flushes buffered entries");
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0020);
    repeat (5) applyStimulus(1'b1, 1'b0, 32'd0);

    $display("[TB] misaligned redirect faults, then recovery");
    applyStimulus(1'b1, 1'b1, 32'h0000_0022);
    repeat (5) applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0000);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'd0);

    $display("[TB] sequential fetch runs off the end of memory");
    applyStimulus(1'b1, 1'b1, 32'h0000_0FF0);
    repeat (10) applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_1000);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'd0);

    $display("[TB] randomized traffic");
    applyStimulus(1'b1, 1'b1, 32'h0000_0000);
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 99) < 6);
      sel = int'($urandom_range(0, 15));
      if (sel == 0) begin
        tgt = ($urandom_range(0, 1023) << 2) | 32'($urandom_range(1, 3));
      end else if (sel == 1) begin
        tgt = 32'h0000_0FF0 + ($urandom_range(0, 3) << 2);
      end else if (sel == 2) begin
        tgt = $urandom;
      end else begin
        tgt = $urandom_range(0, 1023) << 2;
      end
      applyStimulus($urandom_range(0, 99) < 70, rd, tgt);
    end

    $display("[TB] asynchronous reset with a full buffer");
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'd0);
    bus.id_ready = 1'b1;
    doReset();
    repeat (6) applyStimulus(1'b1, 1'b0, 32'd0);

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
